// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer issuing instruction-RAM reads and presenting words to decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        Enable,
    output logic        RW_ram,
    output logic [31:0] Address_in,
    input  logic [31:0] Out,
    output logic [31:0] instruction,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic        Halted
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALTED} state_t;
    state_t      state, state_n;
    logic [31:0] pc_n, instr_n;
    logic        redirect;
    function automatic logic [31:0] wrap(input logic [31:0] a);
        return a % 32'(MEM_DEPTH);
    endfunction
    assign redirect    = Branch_Taken && (state == FETCH || state == WAIT || state == ISSUE);
    assign Enable      = state == FETCH;
    assign Instr_Valid = state == ISSUE;
    assign Halted      = state == HALTED;
    assign RW_ram      = 1'b1;
    assign Address_in  = PC;
    // next state, PC and held word; a redirect overrides every other transition
    always_comb begin
        state_n = state;
        pc_n    = PC;
        instr_n = instruction;
        case (state)
            IDLE:    state_n = Run ? FETCH : IDLE;
            FETCH:   state_n = WAIT;
            WAIT: begin
                instr_n = Out;
                pc_n    = wrap(PC + 32'd1);
                state_n = ISSUE;
            end
            ISSUE:   state_n = Stall ? ISSUE : (instruction == HALT_WORD) ? HALTED : Run ? FETCH : IDLE;
            default: state_n = HALTED;
        endcase
        if (redirect) begin
            state_n = FETCH;
            pc_n    = wrap(Branch_Target);
            instr_n = instruction;
        end
    end
    // state, PC and instruction registers with immediate reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            instruction <= 32'd0;
        end else begin
            state       <= state_n;
            PC          <= pc_n;
            instruction <= instr_n;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of two fetch units (256-word and 8-word RAMs) against a behavioural model
module tb_instruction_fetch;
    logic        Clk = 1'b0;
    logic        Reset, Run, Stall, Branch_Taken;
    logic [31:0] Branch_Target;
    logic        en0, rw0, iv0, h0, en8, rw8, iv8, h8;
    logic [31:0] a0, o0, ins0, pc0, a8, o8, ins8, pc8;
    logic [31:0] mem0 [256];
    logic [31:0] mem8 [8];
    int compared = 0;
    int mismatched = 0;

    int          ph [2] = '{0, 0};
    logic [31:0] mpc [2] = '{32'd0, 32'd7};
    logic [31:0] mins [2] = '{32'd0, 32'd0};

    always #5 Clk = ~Clk;

    instruction_fetch dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .Enable(en0), .RW_ram(rw0), .Address_in(a0), .Out(o0),
        .instruction(ins0), .Instr_Valid(iv0), .PC(pc0), .Halted(h0)
    );

    instruction_fetch #(.RESET_PC(32'd7), .MEM_DEPTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .Enable(en8), .RW_ram(rw8), .Address_in(a8), .Out(o8),
        .instruction(ins8), .Instr_Valid(iv8), .PC(pc8), .Halted(h8)
    );

    always @(posedge Clk) begin
        if (en0) o0 <= mem0[a0[7:0]];
        if (en8) o8 <= mem8[a8[2:0]];
    end

    function automatic logic [31:0] word(int k, logic [31:0] a);
        return k == 0 ? mem0[a[7:0]] : mem8[a[2:0]];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // model phases: 0 idle, 1 read issued, 2 data returning, 3 word offered, 4 stopped
    always @(posedge Clk or posedge Reset) begin
        for (int k = 0; k < 2; k++) begin
            int depth;
            depth = k == 0 ? 256 : 8;
            if (Reset) begin
                ph[k] = 0; mpc[k] = k == 0 ? 32'd0 : 32'd7; mins[k] = 32'd0;
            end else if (Branch_Taken && ph[k] >= 1 && ph[k] <= 3) begin
                mpc[k] = Branch_Target % depth; ph[k] = 1;
            end else if (ph[k] == 0) begin
                if (Run) ph[k] = 1;
            end else if (ph[k] == 1) begin
                ph[k] = 2;
            end else if (ph[k] == 2) begin
                mins[k] = word(k, mpc[k]); mpc[k] = (mpc[k] + 1) % depth; ph[k] = 3;
            end else if (ph[k] == 3 && !Stall) begin
                ph[k] = mins[k] == 32'hFFFFFFFF ? 4 : Run ? 1 : 0;
            end
        end
    end

    // every cycle both units are compared with the model on the falling edge
    always @(negedge Clk) begin
        chk("en0", {31'd0, en0}, {31'd0, ph[0] == 1});
        chk("iv0", {31'd0, iv0}, {31'd0, ph[0] == 3});
        chk("h0", {31'd0, h0}, {31'd0, ph[0] == 4});
        chk("rw0", {31'd0, rw0}, 32'd1);
        chk("pc0", pc0, mpc[0]);
        chk("addr0", a0, mpc[0]);
        chk("ins0", ins0, mins[0]);
        chk("en8", {31'd0, en8}, {31'd0, ph[1] == 1});
        chk("iv8", {31'd0, iv8}, {31'd0, ph[1] == 3});
        chk("h8", {31'd0, h8}, {31'd0, ph[1] == 4});
        chk("pc8", pc8, mpc[1]);
        chk("ins8", ins8, mins[1]);
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem0[i] = 32'hA0000000 | i;
        mem0[0] = 32'h06280060; mem0[1] = 32'h01000000; mem0[2] = 32'h02000000;
        mem0[5] = 32'hDEAD0005;
        for (int i = 0; i < 8; i++) mem8[i] = 32'hB0000000 | i;
        mem8[7] = 32'h12345678; mem8[0] = 32'hFFFFFFFF;
        Reset = 1'b1; Run = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'd0;
        tick(2);
        chk("rst_en", {31'd0, en0}, 32'd0);
        chk("rst_pc", pc0, 32'd0);
        chk("rst_pc8", pc8, 32'd7);
        chk("rst_ins", ins0, 32'd0);
        Reset = 1'b0; Run = 1'b1;
        tick();
        chk("e1_en", {31'd0, en0}, 32'd1);
        chk("e1_addr", a0, 32'd0);
        chk("e1_addr8", a8, 32'd7);
        tick();
        chk("e2_en", {31'd0, en0}, 32'd0);
        tick();
        chk("w0_iv", {31'd0, iv0}, 32'd1);
        chk("w0_ins", ins0, 32'h06280060);
        chk("w0_pc", pc0, 32'd1);
        chk("w7_pc8", pc8, 32'd0);
        tick();
        chk("f1_addr", a0, 32'd1);
        chk("f0_addr8", a8, 32'd0);
        chk("f0_en8", {31'd0, en8}, 32'd1);
        tick(2);
        chk("w1_ins", ins0, 32'h01000000);
        chk("halt_word8", ins8, 32'hFFFFFFFF);
        tick();
        chk("f2_addr", a0, 32'd2);
        chk("halted8", {31'd0, h8}, 32'd1);
        chk("halted8_en", {31'd0, en8}, 32'd0);
        tick(2);
        chk("w2_ins", ins0, 32'h02000000);
        chk("w2_pc", pc0, 32'd3);
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_iv", {31'd0, iv0}, 32'd1);
            chk("stall_ins", ins0, 32'h02000000);
            chk("stall_en", {31'd0, en0}, 32'd0);
            chk("stall_pc", pc0, 32'd3);
        end
        Stall = 1'b0;
        tick();
        chk("rel_en", {31'd0, en0}, 32'd1);
        chk("rel_addr", a0, 32'd3);
        tick(6);
        chk("f5_addr", a0, 32'd5);
        tick();
        Branch_Taken = 1'b1; Branch_Target = 32'd40;
        tick();
        Branch_Taken = 1'b0;
        chk("br_en", {31'd0, en0}, 32'd1);
        chk("br_addr", a0, 32'd40);
        chk("br_iv", {31'd0, iv0}, 32'd0);
        chk("br_h8", {31'd0, h8}, 32'd1);
        chk("br_en8", {31'd0, en8}, 32'd0);
        tick(2);
        chk("br_ins", ins0, 32'hA0000028);
        chk("br_pc", pc0, 32'd41);
        tick(2);
        Run = 1'b0;
        tick();
        chk("rd_iv", {31'd0, iv0}, 32'd1);
        chk("rd_ins", ins0, 32'hA0000029);
        tick();
        chk("rd_idle_en", {31'd0, en0}, 32'd0);
        chk("rd_idle_iv", {31'd0, iv0}, 32'd0);
        tick(2);
        chk("rd_hold_en", {31'd0, en0}, 32'd0);
        Run = 1'b1;
        tick();
        chk("rr_en", {31'd0, en0}, 32'd1);
        chk("rr_addr", a0, 32'd42);
        Branch_Taken = 1'b1; Branch_Target = 32'd9;
        tick();
        Branch_Taken = 1'b0;
        chk("bf_en", {31'd0, en0}, 32'd1);
        chk("bf_addr", a0, 32'd9);
        #2 Reset = 1'b1;
        #1;
        chk("ar_en", {31'd0, en0}, 32'd0);
        chk("ar_iv", {31'd0, iv0}, 32'd0);
        chk("ar_h", {31'd0, h0}, 32'd0);
        chk("ar_pc", pc0, 32'd0);
        chk("ar_h8", {31'd0, h8}, 32'd0);
        chk("ar_pc8", pc8, 32'd7);
        tick(2);
        Reset = 1'b0;
        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
